// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM register, data-memory req/ack access,
// and MEM/WB register. Ports: EX-stage inputs (ex_*), data-memory
// handshake (dmem_*), mem_stall to the front end, mem_* MEM-stage
// forwarding source, wb_* MEM/WB outputs and WB forwarding source.
module mem_stage (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ex_valid,
    input  logic        ex_flush,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_mem_write_data,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_reg_write,
    input  logic        ex_mem_to_reg,
    input  logic [2:0]  ex_funct3,
    input  logic [4:0]  ex_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_reg_write,
    output logic [4:0]  mem_rd,
    output logic [31:0] mem_forward_value,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_value,
    output logic        wb_misaligned
);

    typedef struct packed {
        logic        valid;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] wdata;
    } ex_mem_t;

    typedef enum logic {IDLE, WAIT} state_t;

    ex_mem_t em, em_d;
    state_t  state, state_d;

    logic        word, half, is_mem;
    logic        mis_addr, mis, pending;
    logic [1:0]  lane;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // EX/MEM: bubble on flush or invalid EX
    always_comb begin
        em_d = '0;
        if (ex_valid && !ex_flush) begin
            em_d.valid      = 1'b1;
            em_d.mem_read   = ex_mem_read;
            em_d.mem_write  = ex_mem_write;
            em_d.reg_write  = ex_reg_write;
            em_d.mem_to_reg = ex_mem_to_reg;
            em_d.funct3     = ex_funct3;
            em_d.rd         = ex_rd;
            em_d.alu        = ex_alu_result;
            em_d.wdata      = ex_mem_write_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            em <= '0;
        end else if (!mem_stall) begin
            em <= em_d;
        end
    end

    // funct3[1] set covers LW/SW and the undefined encodings
    assign lane   = em.alu[1:0];
    assign word   = em.funct3[1];
    assign half   = (em.funct3[1:0] == 2'b01);
    assign is_mem = em.mem_read | em.mem_write;

    always_comb begin
        mis_addr = 1'b0;
        unique case (1'b1)
            word:    mis_addr = (lane != 2'b00);
            half:    mis_addr = lane[0];
            default: mis_addr = 1'b0;
        endcase
    end

    assign mis     = em.valid & is_mem & mis_addr;
    assign pending = em.valid & is_mem & ~mis_addr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        dmem_req = 1'b0;
        unique case (state)
            IDLE: begin
                dmem_req = pending;
                if (pending && !dmem_ack) state_d = WAIT;
            end
            WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_stall = dmem_req & ~dmem_ack;
    assign dmem_we   = em.mem_write;
    assign dmem_addr = {em.alu[31:2], 2'b00};

    always_comb begin
        dmem_be    = 4'b0000;
        dmem_wdata = em.wdata;
        unique case (1'b1)
            word: dmem_be = 4'b1111;
            half: begin
                dmem_be    = lane[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = {2{em.wdata[15:0]}};
            end
            default: begin
                dmem_be    = 4'b0001 << lane;
                dmem_wdata = {4{em.wdata[7:0]}};
            end
        endcase
    end

    assign ld_byte = 8'(dmem_rdata >> {lane, 3'b000});
    assign ld_half = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        ld_data = dmem_rdata;
        unique case (1'b1)
            word: ld_data = dmem_rdata;
            half: ld_data = em.funct3[2] ? {16'h0, ld_half}
                                         : {{16{ld_half[15]}}, ld_half};
            default: ld_data = em.funct3[2] ? {24'h0, ld_byte}
                                            : {{24{ld_byte[7]}}, ld_byte};
        endcase
    end

    assign mem_reg_write     = em.valid & em.reg_write & ~mis;
    assign mem_rd            = em.rd;
    assign mem_forward_value = em.alu;

    // A stalled cycle retires nothing, so WB sees each op once
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_rd         <= 5'd0;
            wb_value      <= 32'd0;
            wb_misaligned <= 1'b0;
        end else if (mem_stall) begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_misaligned <= 1'b0;
        end else begin
            wb_valid      <= em.valid;
            wb_reg_write  <= mem_reg_write;
            wb_rd         <= em.rd;
            wb_value      <= em.mem_to_reg ? ld_data : em.alu;
            wb_misaligned <= mis;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: scoreboard of expected WB results
// plus per-scenario checks of the data-memory handshake.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_flush = 1'b0;
    logic [31:0] ex_alu_result = '0;
    logic [31:0] ex_mem_write_data = '0;
    logic        ex_mem_read = 1'b0;
    logic        ex_mem_write = 1'b0;
    logic        ex_reg_write = 1'b0;
    logic        ex_mem_to_reg = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic [4:0]  ex_rd = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        mem_stall, mem_reg_write;
    logic [4:0]  mem_rd;
    logic [31:0] mem_forward_value;
    logic        wb_valid, wb_reg_write, wb_misaligned;
    logic [4:0]  wb_rd;
    logic [31:0] wb_value;

    mem_stage dut (
        .clk(clk), .rstn(rstn),
        .ex_valid(ex_valid), .ex_flush(ex_flush),
        .ex_alu_result(ex_alu_result),
        .ex_mem_write_data(ex_mem_write_data),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_funct3(ex_funct3), .ex_rd(ex_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .mem_forward_value(mem_forward_value),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_value(wb_value),
        .wb_misaligned(wb_misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        mis;
        logic        chk;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    // memory model: ack after ack_delay req cycles
    int          ack_delay = 0;
    int          wcnt = 0;
    int          req_cycles = 0;
    int          stall_cycles = 0;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_be;
    logic        last_we;

    always @(negedge clk) begin
        dmem_ack = dmem_req && (wcnt >= ack_delay);
    end

    always @(posedge clk) begin
        if (!rstn || !dmem_req || dmem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (mem_stall) stall_cycles++;
        if (dmem_req) begin
            req_cycles++;
            last_addr  = dmem_addr;
            last_wdata = dmem_wdata;
            last_be    = dmem_be;
            last_we    = dmem_we;
        end
    end

    // scoreboard: every valid WB entry must match the oldest expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (wb_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected rd=%0d value=%h",
                         wb_rd, wb_value);
            end else begin
                e = sb.pop_front();
                if (wb_reg_write !== e.rw || wb_rd !== e.rd ||
                    wb_misaligned !== e.mis ||
                    (e.chk && wb_value !== e.val)) begin
                    failures++;
                    $display("FAIL sb_wb got rw=%b rd=%0d mis=%b v=%h exp rw=%b rd=%0d mis=%b v=%h",
                             wb_reg_write, wb_rd, wb_misaligned, wb_value,
                             e.rw, e.rd, e.mis, e.val);
                end
            end
        end
    end

    task automatic clr_stats();
        req_cycles   = 0;
        stall_cycles = 0;
    endtask

    task automatic issue(
        input logic        rd_m,
        input logic        wr_m,
        input logic        rw,
        input logic        m2r,
        input logic [2:0]  f3,
        input logic [4:0]  rd,
        input logic [31:0] alu,
        input logic [31:0] wd,
        input logic [31:0] ev,
        input logic        emis,
        input logic        chk
    );
        bit ok;
        exp_t e;
        @(negedge clk);
        ex_valid          = 1'b1;
        ex_flush          = 1'b0;
        ex_mem_read       = rd_m;
        ex_mem_write      = wr_m;
        ex_reg_write      = rw;
        ex_mem_to_reg     = m2r;
        ex_funct3         = f3;
        ex_rd             = rd;
        ex_alu_result     = alu;
        ex_mem_write_data = wd;
        e.rw  = rw & ~emis;
        e.rd  = rd;
        e.val = ev;
        e.mis = emis;
        e.chk = chk;
        sb.push_back(e);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (!mem_stall) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout rd=%0d", rd);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        ex_valid = 1'b0;
        ex_flush = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({dmem_req, mem_stall, wb_valid, wb_reg_write,
             wb_misaligned, mem_reg_write} !== 6'b0 ||
            wb_value !== 32'd0 || wb_rd !== 5'd0 ||
            mem_rd !== 5'd0 || mem_forward_value !== 32'd0) begin
            failures++;
            $display("FAIL reset_state req=%b stall=%b wbv=%b val=%h",
                     dmem_req, mem_stall, wb_valid, wb_value);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_sw();
        ack_delay = 0;
        @(negedge clk);
        clr_stats();
        issue(0, 1, 0, 0, 3'b010, 5'd0, 32'h100, 32'hDEADBEEF,
              32'h0, 0, 0);
        @(negedge clk);
        ex_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0) begin
            failures++;
            $display("FAIL sw_wb_next got v=%b rw=%b exp v=1 rw=0",
                     wb_valid, wb_reg_write);
        end
        idle(2);
        checks++;
        if (req_cycles != 1 || stall_cycles != 0) begin
            failures++;
            $display("FAIL sw_cycles got req=%0d stall=%0d exp 1 0",
                     req_cycles, stall_cycles);
        end
        checks++;
        if (last_addr !== 32'h100 || last_be !== 4'b1111 ||
            last_wdata !== 32'hDEADBEEF || last_we !== 1'b1) begin
            failures++;
            $display("FAIL sw_bus got a=%h be=%b d=%h we=%b",
                     last_addr, last_be, last_wdata, last_we);
        end
    endtask

    task automatic test_lb_delay();
        ack_delay  = 3;
        dmem_rdata = 32'h80FF_FF7F;
        @(negedge clk);
        clr_stats();
        issue(1, 0, 1, 1, 3'b000, 5'd7, 32'h203, 32'h0,
              32'hFFFF_FF80, 0, 1);
        @(negedge clk);
        ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (wb_valid !== 1'b0 || mem_stall !== 1'b1) begin
                failures++;
                $display("FAIL lb_stall_%0d got wbv=%b stall=%b exp 0 1",
                         i, wb_valid, mem_stall);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (wb_valid !== 1'b1 || wb_value !== 32'hFFFF_FF80 ||
            wb_rd !== 5'd7) begin
            failures++;
            $display("FAIL lb_retire got v=%b val=%h rd=%0d",
                     wb_valid, wb_value, wb_rd);
        end
        idle(1);
        checks++;
        if (stall_cycles != 3 || last_addr !== 32'h200) begin
            failures++;
            $display("FAIL lb_cycles got stall=%0d a=%h exp 3 200",
                     stall_cycles, last_addr);
        end
        ack_delay = 0;
    endtask

    task automatic test_lanes();
        ack_delay  = 0;
        dmem_rdata = 32'hABCD_1234;
        @(negedge clk);
        clr_stats();
        issue(1, 0, 1, 1, 3'b101, 5'd9, 32'h002, 32'h0,
              32'h0000_ABCD, 0, 1);
        issue(0, 1, 0, 0, 3'b000, 5'd0, 32'h001, 32'h55,
              32'h0, 0, 0);
        idle(2);
        checks++;
        if (req_cycles != 2 || stall_cycles != 0) begin
            failures++;
            $display("FAIL b2b_cycles got req=%0d stall=%0d exp 2 0",
                     req_cycles, stall_cycles);
        end
        checks++;
        if (last_be !== 4'b0010 || last_wdata !== 32'h5555_5555 ||
            last_addr !== 32'h0) begin
            failures++;
            $display("FAIL sb_lane got be=%b d=%h a=%h",
                     last_be, last_wdata, last_addr);
        end
        issue(0, 1, 0, 0, 3'b001, 5'd0, 32'h006, 32'h1234_BEEF,
              32'h0, 0, 0);
        idle(2);
        checks++;
        if (last_be !== 4'b1100 || last_wdata !== 32'hBEEF_BEEF ||
            last_addr !== 32'h4) begin
            failures++;
            $display("FAIL sh_lane got be=%b d=%h a=%h",
                     last_be, last_wdata, last_addr);
        end
        dmem_rdata = 32'h1234_8001;
        issue(1, 0, 1, 1, 3'b001, 5'd10, 32'h000, 32'h0,
              32'hFFFF_8001, 0, 1);
        issue(1, 0, 1, 1, 3'b100, 5'd11, 32'h002, 32'h0,
              32'h0000_0034, 0, 1);
        issue(1, 0, 1, 1, 3'b010, 5'd12, 32'h008, 32'h0,
              32'h1234_8001, 0, 1);
        idle(2);
    endtask

    task automatic test_misaligned();
        ack_delay = 0;
        @(negedge clk);
        clr_stats();
        issue(1, 0, 1, 1, 3'b010, 5'd3, 32'h1001, 32'h0,
              32'h0, 1, 0);
        #1;
        checks++;
        if (dmem_req !== 1'b0 || mem_reg_write !== 1'b0) begin
            failures++;
            $display("FAIL mis_mem got req=%b mrw=%b exp 0 0",
                     dmem_req, mem_reg_write);
        end
        issue(0, 1, 0, 0, 3'b001, 5'd0, 32'h0003, 32'h0,
              32'h0, 1, 0);
        idle(2);
        checks++;
        if (req_cycles != 0) begin
            failures++;
            $display("FAIL mis_req got req=%0d exp 0", req_cycles);
        end
    endtask

    task automatic test_flush_fwd();
        bit ok;
        exp_t e;
        ack_delay  = 2;
        dmem_rdata = 32'h0BAD_F00D;
        issue(1, 0, 1, 1, 3'b010, 5'd4, 32'h300, 32'h0,
              32'h0BAD_F00D, 0, 1);
        @(negedge clk);
        ex_valid      = 1'b1;
        ex_flush      = 1'b1;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_reg_write  = 1'b1;
        ex_mem_to_reg = 1'b0;
        ex_funct3     = 3'b000;
        ex_rd         = 5'd5;
        ex_alu_result = 32'h42;
        e.rw  = 1'b1;
        e.rd  = 5'd5;
        e.val = 32'h42;
        e.mis = 1'b0;
        e.chk = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        ex_flush = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (!mem_stall) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        checks++;
        if (!ok || mem_forward_value !== 32'h42 || mem_rd !== 5'd5 ||
            mem_reg_write !== 1'b1) begin
            failures++;
            $display("FAIL fwd_after_stall got v=%h rd=%0d mrw=%b",
                     mem_forward_value, mem_rd, mem_reg_write);
        end
        @(negedge clk);
        ex_rd    = 5'd6;
        ex_flush = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (mem_reg_write !== 1'b0 || mem_rd !== 5'd0) begin
            failures++;
            $display("FAIL flush_bubble got mrw=%b rd=%0d exp 0 0",
                     mem_reg_write, mem_rd);
        end
        idle(2);
        ack_delay = 0;
    endtask

    task automatic test_reset_wait();
        ack_delay = 100;
        issue(1, 0, 1, 1, 3'b010, 5'd2, 32'h400, 32'h0,
              32'h0, 0, 1);
        @(negedge clk);
        ex_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (dmem_req !== 1'b1 || mem_stall !== 1'b1) begin
            failures++;
            $display("FAIL wait_pre got req=%b stall=%b exp 1 1",
                     dmem_req, mem_stall);
        end
        rstn = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0 ||
            wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_wait got req=%b stall=%b wbv=%b",
                     dmem_req, mem_stall, wb_valid);
        end
        ack_delay = 0;
        @(negedge clk);
        rstn = 1'b1;
        clr_stats();
        dmem_rdata = 32'h1234_5678;
        issue(1, 0, 1, 1, 3'b010, 5'd8, 32'h404, 32'h0,
              32'h1234_5678, 0, 1);
        idle(2);
        checks++;
        if (req_cycles != 1 || last_addr !== 32'h404) begin
            failures++;
            $display("FAIL post_reset_lw got req=%0d a=%h exp 1 404",
                     req_cycles, last_addr);
        end
    endtask

    initial begin
        test_reset();
        test_sw();
        test_lb_delay();
        test_lanes();
        test_misaligned();
        test_flush_fwd();
        test_reset_wait();
        idle(3);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got pending=%0d exp 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
